regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file among NUM_REQ writeback requesters: ALU, load/store unit and mul/div unit.
- Each requester uses a valid/ready handshake.
- A round-robin pointer guarantees starvation freedom.
- Sits between the execute/memory units and the register file write port (wr_en/wr_addr/wr_data).

Parameters:
- DATA_WIDTH, 32, register data width.
- REG_MEM_ADDR_WIDTH, 5, register address width.
- NUM_REQ, 3, number of writeback requesters (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  NUM_REQ x REG_MEM_ADDR_WIDTH  per-requester destination register.
- req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_ready_o  out  NUM_REQ  per-requester accept; transfer when valid&&ready at the rising edge.
- wr_en_o  out  1  register file write enable.
- wr_addr_o  out  REG_MEM_ADDR_WIDTH  register file write address.
- wr_data_o  out  DATA_WIDTH  register file write data.
- grant_id_o  out  $clog2(NUM_REQ)  index of the granted requester; valid only when wr_en_o=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Output timing:
  - Outputs are combinational from the requests and the registered pointer.
  - The register file commits at the same edge as the handshake, so there is zero added latency.
- Reset:
  - rr_ptr=0.
  - While rst=1: wr_en_o=0, req_ready_o=0, wr_addr_o=0, wr_data_o=0, grant_id_o=0.
- Request classes:
  - A "real" request is req_valid_i[i]=1 with req_addr_i[i]!=0.
  - An "x0" request is req_valid_i[i]=1 with req_addr_i[i]==0.
- x0 requests:
  - Every x0 request gets req_ready_o[i]=1 in the same cycle and is discarded.
  - They do not consume the port and do not move rr_ptr.
- Arbitration:
  - Among real requests, grant the first set index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Granted index g: req_ready_o[g]=1, wr_en_o=1, wr_addr_o=req_addr_i[g], wr_data_o=req_data_i[g], grant_id_o=g.
  - All other real requests see ready=0.
- Pointer update: on a clock edge with a real grant, rr_ptr <= (g+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0). No real grant: rr_ptr holds.
- No requests: wr_en_o=0, wr_addr_o=0, wr_data_o=0, all ready=0.
- Requester rule:
  - Once valid is asserted, valid, addr and data hold stable until the handshake.
  - The arbiter does not buffer; a lost request is a requester bug.
- Same-address conflict: two real requests to the same register in one cycle are serialised in round-robin order; the later grant overwrites.
- Starvation bound: a continuously valid real request is granted within NUM_REQ cycles.
- Reset mid-operation: pending requests are neither granted nor acknowledged. After rst deasserts, arbitration restarts from rr_ptr=0.

Optional Feature:
- Macro: REGFILE_WB_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (NUM_REQ x 16).
  - Each counter increments on every cycle requester i has a real request with ready=0.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Adds output conflict_o (1): high in any cycle with two or more real requests.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Package regfile_wb_arb_pkg:
  - Requester indices REQ_ALU=0, REQ_LSU=1, REQ_MDU=2.
  - Default NUM_REQ=3.
  - Type req_idx_t (logic [$clog2(NUM_REQ)-1:0]).
  - X0_ADDR constant = '0.
- Sub-module rr_arbiter:
  - Generic NUM_REQ round-robin: req vector in, one-hot grant and index out.
  - Owns rr_ptr, with clk and rst.
- Top level handles x0 filtering, data muxing and the optional stats.

Test Plan:
- Reset + idle: rst=1 with all valids=1 -> wr_en_o=0 and all ready=0. Release rst, no valids -> wr_en_o=0, rr_ptr=0.
- Single request: valid[1]=1, addr=5, data=32'hDEAD_BEEF -> same cycle ready[1]=1, wr_en_o=1, wr_addr_o=5, wr_data_o=32'hDEAD_BEEF, grant_id_o=1. Register file read of x5 after the edge returns DEADBEEF.
- Round-robin fairness: all three hold real requests (addr 1,2,3; data 10,20,30) from rr_ptr=0, each dropping valid after its grant -> grants 0,1,2 on consecutive cycles; rr_ptr wraps to 0.
- x0 filtering: valid[0] addr=0 together with valid[2] addr=7 data=7 -> ready[0]=1 and ready[2]=1 in the same cycle; wr_en_o=1, wr_addr_o=7; rr_ptr becomes 0. Register file x0 reads 0.
- Same-address conflict: req0 and req1 both addr=4, data 11 and 22, rr_ptr=0 -> cycle 1 writes 11, cycle 2 writes 22; x4 finally reads 22.
- Reset mid-contention: assert rst while 3 requests are pending -> all ready=0 immediately (asynchronous). After release, first grant goes to requester 0. With REGFILE_WB_ARB_STATS_EN defined, stall counters read 0.

Source files
------------

// File: rtl/regfile_wb_arb_pkg.sv
// Shared constants and types for the register file writeback arbiter.
// Requester indices, default sizing, grant index type and the x0 address.
package regfile_wb_arb_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

  localparam logic [DEF_ADDR_W-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Writeback request bundle: per-requester valid/addr/data and ready.
// master = requester side, slave = arbiter side.
interface regfile_wb_arb_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5,
  parameter int NUM_REQ            = 3
);

  logic [NUM_REQ-1:0]                         req_valid_i;
  logic [NUM_REQ-1:0][REG_MEM_ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         req_data_i;
  logic [NUM_REQ-1:0]                         req_ready_o;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: req vector in, one-hot grant + index out.
// Ports: clk, rst, req_i, gnt_o, gnt_idx_o, gnt_vld_o. Owns rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_vld_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] ptr_nxt;
  int            idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

  always_comb begin
    if (gnt_idx_o == IW'(NUM_REQ - 1))
      ptr_nxt = '0;
    else
      ptr_nxt = gnt_idx_o + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (gnt_vld_o)
      rr_ptr <= ptr_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback requesters.
// Ports: clk, rst, req (slave bundle), wr_en/addr/data, grant_id;
// REGFILE_WB_ARB_STATS_EN adds stall_cnt_o and conflict_o.
module regfile_wb_arbiter
  import regfile_wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_MEM_ADDR_WIDTH = 5,
  parameter int NUM_REQ            = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst,
  regfile_wb_arb_if.slave               req,
  output logic                          wr_en_o,
  output logic [REG_MEM_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
`ifdef REGFILE_WB_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0]      stall_cnt_o,
  output logic                          conflict_o,
`endif
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam logic [REG_MEM_ADDR_WIDTH-1:0] X0 =
    REG_MEM_ADDR_WIDTH'(X0_ADDR);

  logic [NUM_REQ-1:0]         real_req;
  logic [NUM_REQ-1:0]         x0_req;
  logic [NUM_REQ-1:0]         gnt;
  logic [$clog2(NUM_REQ)-1:0] gnt_idx;
  logic                       gnt_vld;

  // x0 writes are acked and dropped without touching the port.
  always_comb begin
    real_req = '0;
    x0_req   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req.req_valid_i[i] && !rst) begin
        if (req.req_addr_i[i] == X0) x0_req[i]   = 1'b1;
        else                         real_req[i] = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (real_req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req.req_ready_o = x0_req | gnt;
  assign wr_en_o         = gnt_vld;
  assign grant_id_o      = gnt_idx;

  always_comb begin
    wr_addr_o = '0;
    wr_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wr_addr_o = req.req_addr_i[i];
        wr_data_o = req.req_data_i[i];
      end
    end
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  int unsigned n_real;

  always_comb begin
    n_real = 0;
    for (int i = 0; i < NUM_REQ; i++)
      n_real = n_real + 32'(real_req[i]);
    conflict_o = (n_real >= 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (real_req[i] && !gnt[i] &&
            stall_cnt_o[i] != 16'hFFFF)
          stall_cnt_o[i] <= stall_cnt_o[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table + scoreboard,
// with hand-written reset sequences and a register file model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  gid;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [2:0][15:0] stall_cnt;
  logic             conflict;
`endif

  always #5 clk = ~clk;

  regfile_wb_arb_if #(
    .DATA_WIDTH (32),
    .REG_MEM_ADDR_WIDTH (5),
    .NUM_REQ (3)
  ) bus ();

  regfile_wb_arbiter #(
    .DATA_WIDTH (32),
    .REG_MEM_ADDR_WIDTH (5),
    .NUM_REQ (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
`ifdef REGFILE_WB_ARB_STATS_EN
    .stall_cnt_o (stall_cnt),
    .conflict_o  (conflict),
`endif
    .grant_id_o (gid)
  );

  logic [31:0] rf [32];

  initial for (int i = 0; i < 32; i++) rf[i] = '0;

  always @(posedge clk)
    if (wr_en) rf[wr_addr] <= wr_data;

  typedef struct {
    logic [2:0]       v;
    logic [2:0][4:0]  a;
    logic [2:0][31:0] d;
    logic [2:0]       rdy;
    logic             en;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic [1:0]       g;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];
  vec_t exp_q [$];
  vec_t e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [2:0][4:0] a,
                       input logic [2:0][31:0] d);
    bus.req_valid_i = v;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
  endtask

  initial begin
    tbl[0]  = '{3'b000, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd0},
                3'b000, 1'b0, 5'd0, 32'd0, 2'd0};
    tbl[1]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10},
                3'b001, 1'b1, 5'd1, 32'd10, 2'd0};
    tbl[2]  = '{3'b110, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10},
                3'b010, 1'b1, 5'd2, 32'd20, 2'd1};
    tbl[3]  = '{3'b100, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10},
                3'b100, 1'b1, 5'd3, 32'd30, 2'd2};
    tbl[4]  = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0},
                3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1};
    tbl[5]  = '{3'b101, {5'd7, 5'd0, 5'd0}, {32'd7, 32'd0, 32'd99},
                3'b101, 1'b1, 5'd7, 32'd7, 2'd2};
    tbl[6]  = '{3'b011, {5'd0, 5'd4, 5'd4}, {32'd0, 32'd22, 32'd11},
                3'b001, 1'b1, 5'd4, 32'd11, 2'd0};
    tbl[7]  = '{3'b010, {5'd0, 5'd4, 5'd4}, {32'd0, 32'd22, 32'd11},
                3'b010, 1'b1, 5'd4, 32'd22, 2'd1};
    tbl[8]  = '{3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd55},
                3'b001, 1'b0, 5'd0, 32'd0, 2'd0};
    tbl[9]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10},
                3'b100, 1'b1, 5'd3, 32'd30, 2'd2};
    tbl[10] = '{3'b011, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10},
                3'b001, 1'b1, 5'd1, 32'd10, 2'd0};

    rst = 1'b1;
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1});
    #3;
    check("rst_en", 64'(wr_en), 64'd0);
    check("rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("rst_addr", 64'(wr_addr), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_gid", 64'(gid), 64'd0);

    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_ready", i), 64'(bus.req_ready_o), 64'(e.rdy));
      check($sformatf("v%0d_en", i), 64'(wr_en), 64'(e.en));
      check($sformatf("v%0d_addr", i), 64'(wr_addr), 64'(e.wa));
      check($sformatf("v%0d_data", i), 64'(wr_data), 64'(e.wd));
      if (e.en)
        check($sformatf("v%0d_gid", i), 64'(gid), 64'(e.g));
      @(posedge clk); #1;
    end

    check("rf_x5", 64'(rf[5]), 64'hDEADBEEF);
    check("rf_x4", 64'(rf[4]), 64'd22);
    check("rf_x7", 64'(rf[7]), 64'd7);
    check("rf_x3", 64'(rf[3]), 64'd30);
    check("rf_x0", 64'(rf[0]), 64'd0);

    // rr_ptr is 1 here; reset mid-contention must restart from 0.
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'd30, 32'd20, 32'd10});
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.req_ready_o), 64'd0);
    check("mid_rst_en", 64'(wr_en), 64'd0);
`ifdef REGFILE_WB_ARB_STATS_EN
    check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
    check("conflict_rst", 64'(conflict), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gid", 64'(gid), 64'd0);
    check("post_rst_ready", 64'(bus.req_ready_o), 64'b001);
    check("post_rst_en", 64'(wr_en), 64'd1);
`ifdef REGFILE_WB_ARB_STATS_EN
    check("conflict_hi", 64'(conflict), 64'd1);
    @(posedge clk); #1;
    check("stall_cnt_1", 64'(stall_cnt), {16'd0, 16'd1, 16'd1, 16'd0});
`endif
    @(posedge clk); #1;
    drive(3'b000, '0, '0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
